// File: rtl/seg7_scan_ctrl_if.sv
// Load/display bundle for the seven-segment scan controller.
// The blink_mask signal exists only when SEG7_SCAN_BLINK_EN is defined.
interface seg7_scan_ctrl_if;
  logic [15:0] digits_in;
  logic        load;
  logic        lzb;
`ifdef SEG7_SCAN_BLINK_EN
  logic [3:0]  blink_mask;
`endif
  logic        pending;
  logic        frame_tick;
  logic [3:0]  anode;
  logic [6:0]  segment;

`ifdef SEG7_SCAN_BLINK_EN
  modport master (output digits_in, load, lzb, blink_mask,
                  input  pending, frame_tick, anode, segment);
  modport slave  (input  digits_in, load, lzb, blink_mask,
                  output pending, frame_tick, anode, segment);
`else
  modport master (output digits_in, load, lzb,
                  input  pending, frame_tick, anode, segment);
  modport slave  (input  digits_in, load, lzb,
                  output pending, frame_tick, anode, segment);
`endif
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller: guard blanking, leading-zero blanking, frame-boundary commit.
// Optional digit blinking is enabled by defining SEG7_SCAN_BLINK_EN.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
`ifdef SEG7_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input logic             clk,
  input logic             rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] divCnt_q, divCnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pendingReg_q, pendingReg_d;
  logic          pending_q, pending_d;
  logic          frameTick_q;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    segment_q, segment_d;

  logic          wrap;
  logic          frameEnd;
  logic          tickSoon;
  logic          inGuard;
  logic [3:0]    code;
  logic [3:0]    leftClear;
  logic          lzbBlank;
  logic          blinkBlank;
  logic          z3, z2;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd15:   s = 7'b1111111;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // A load in the commit cycle wins for pending: the old value commits, the new one waits a frame.
  always_comb begin
    wrap         = (divCnt_q == CW'(REFRESH_DIV - 1));
    divCnt_d     = wrap ? '0 : divCnt_q + 1'b1;
    idx_d        = wrap ? idx_q - 2'd1 : idx_q;
    frameEnd     = wrap && (idx_q == 2'd0);
    tickSoon     = (divCnt_q == CW'(REFRESH_DIV - 2)) && (idx_q == 2'd0);
    pendingReg_d = bus.load ? bus.digits_in : pendingReg_q;
    pending_d    = bus.load ? 1'b1 : (frameEnd ? 1'b0 : pending_q);
    active_d     = (frameEnd && pending_q) ? pendingReg_q : active_q;
  end

  // leftClear[i] means every digit left of digit i is 0 or blank; digit 0 is never lzb-blanked.
  always_comb begin
    inGuard   = (divCnt_q < CW'(GUARD));
    code      = active_q[{idx_q, 2'b00} +: 4];
    z3        = (active_q[15:12] == 4'h0) || (active_q[15:12] == 4'hF);
    z2        = (active_q[11:8] == 4'h0) || (active_q[11:8] == 4'hF);
    leftClear = {1'b1, z3, z3 & z2, 1'b0};
    lzbBlank  = bus.lzb && (code == 4'h0) && leftClear[idx_q];
    anode_d   = (inGuard || blinkBlank) ? 4'b1111 : ~(4'b0001 << idx_q);
    segment_d = (inGuard || blinkBlank || lzbBlank) ? 7'b1111111 : decode(code);
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blinkCnt_q;
  logic          blinkPhase_q;

  // Phase flips once every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (frameEnd) begin
      if (blinkCnt_q == BW'(BLINK_FRAMES - 1)) begin
        blinkCnt_q   <= '0;
        blinkPhase_q <= ~blinkPhase_q;
      end else begin
        blinkCnt_q <= blinkCnt_q + 1'b1;
      end
    end
  end

  assign blinkBlank = blinkPhase_q && bus.blink_mask[idx_q];
`else
  assign blinkBlank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt_q     <= '0;
      idx_q        <= 2'd3;
      active_q     <= 16'hFFFF;
      pendingReg_q <= 16'hFFFF;
      pending_q    <= 1'b0;
      frameTick_q  <= 1'b0;
      anode_q      <= 4'b1111;
      segment_q    <= 7'b1111111;
    end else begin
      divCnt_q     <= divCnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pendingReg_q <= pendingReg_d;
      pending_q    <= pending_d;
      frameTick_q  <= tickSoon;
      anode_q      <= anode_d;
      segment_q    <= segment_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_tick = frameTick_q;
  assign bus.anode      = anode_q;
  assign bus.segment    = segment_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV=8, GUARD=2 (32-cycle frame).
// frame_tick is high in the last cycle of digit 0's slot; the first digit-3 sample follows it by 4 cycles.
module tb_seg7_scan_ctrl;

  localparam logic [15:0] ALL_AN = 16'b0111_1011_1101_1110;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic waitTick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) found = 1'b1;
    end
  endtask

  task automatic loadDigits(input logic [15:0] v);
    bus.digits_in = v;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  // Samples the middle of each digit slot, digit 3 first.
  task automatic captureFrame(input int lead, output logic [15:0] ans, output logic [27:0] segs);
    for (int d = 3; d >= 0; d--) begin
      repeat ((d == 3) ? lead : 8) @(negedge clk);
      ans[d*4 +: 4]  = bus.anode;
      segs[d*7 +: 7] = bus.segment;
    end
  endtask

  task automatic test_reset();
    logic [3:0] wantAn;
    logic       wantTick;
    int         c, i;
    rst = 1'b1;
    bus.digits_in = 16'h0000;
    bus.load = 1'b0;
    bus.lzb  = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
    bus.blink_mask = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({bus.anode, bus.segment, bus.pending, bus.frame_tick} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_values got an=%b seg=%b pend=%b tick=%b want 1111 1111111 0 0",
               bus.anode, bus.segment, bus.pending, bus.frame_tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      c = (k - 1) % 8;
      i = 3 - ((k - 1) / 8) % 4;
      wantAn   = (c < 2) ? 4'b1111 : ~(4'b0001 << i);
      wantTick = ((k % 32) == 31);
      total++;
      if ({bus.anode, bus.segment, bus.pending, bus.frame_tick} !== {wantAn, 7'b1111111, 1'b0, wantTick}) begin
        bad++;
        $display("[TB] FAIL idle_scan k=%0d got an=%b seg=%b pend=%b tick=%b want %b 1111111 0 %b",
                 k, bus.anode, bus.segment, bus.pending, bus.frame_tick, wantAn, wantTick);
      end
    end
  endtask

  task automatic test_load();
    bit          found;
    logic [15:0] ans;
    logic [27:0] segs;
    loadDigits(16'h1234);
    total++;
    if (bus.pending !== 1'b1) begin
      bad++; $display("[TB] FAIL load_pending got %b want 1", bus.pending);
    end
    waitTick(found);
    total++;
    if (!found || bus.pending !== 1'b1) begin
      bad++; $display("[TB] FAIL load_tick found=%0d pend=%b want 1 1", found, bus.pending);
    end
    captureFrame(4, ans, segs);
    total++;
    if (ans !== ALL_AN) begin
      bad++; $display("[TB] FAIL load_anodes got %b want %b", ans, ALL_AN);
    end
    total++;
    if (segs !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}) begin
      bad++; $display("[TB] FAIL load_1234 got %b want 1001111_0010010_0000110_1001100", segs);
    end
    total++;
    if (bus.pending !== 1'b0) begin
      bad++; $display("[TB] FAIL load_cleared got %b want 0", bus.pending);
    end
  endtask

  task automatic test_back_to_back();
    bit          found;
    logic [15:0] ans;
    logic [27:0] segs;
    loadDigits(16'h1111);
    @(negedge clk);
    loadDigits(16'h5678);
    waitTick(found);
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL b2b_tick got none want frame_tick within 40 cycles");
    end
    captureFrame(4, ans, segs);
    total++;
    if (ans !== ALL_AN || segs !== {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}) begin
      bad++; $display("[TB] FAIL b2b_5678 got an=%b seg=%b want %b 0100100_0100000_0001111_0000000",
                      ans, segs, ALL_AN);
    end
  endtask

  task automatic test_load_on_commit();
    bit          found;
    logic [15:0] ans;
    logic [27:0] segs;
    loadDigits(16'h2222);
    waitTick(found);
    bus.digits_in = 16'h9999;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    total++;
    if (!found || bus.pending !== 1'b1) begin
      bad++; $display("[TB] FAIL collide_pending found=%0d pend=%b want 1 1", found, bus.pending);
    end
    captureFrame(3, ans, segs);
    total++;
    if (ans !== ALL_AN || segs !== {4{7'b0010010}}) begin
      bad++; $display("[TB] FAIL collide_2222 got an=%b seg=%b want %b 4x0010010", ans, segs, ALL_AN);
    end
    waitTick(found);
    total++;
    if (!found || bus.pending !== 1'b1) begin
      bad++; $display("[TB] FAIL collide_still_pending found=%0d pend=%b want 1 1", found, bus.pending);
    end
    captureFrame(4, ans, segs);
    total++;
    if (segs !== {4{7'b0000100}} || bus.pending !== 1'b0) begin
      bad++; $display("[TB] FAIL collide_9999 got seg=%b pend=%b want 4x0000100 0", segs, bus.pending);
    end
  endtask

  task automatic test_lzb();
    bit          found;
    logic [15:0] ans;
    logic [27:0] segs;
    logic [15:0] vec  [4];
    logic [27:0] want [4];
    vec[0] = 16'h0070; want[0] = {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001};
    vec[1] = 16'h0000; want[1] = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
    vec[2] = 16'hA000; want[2] = {4{7'b0000001}};
    vec[3] = 16'hF0F0; want[3] = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
    bus.lzb = 1'b1;
    for (int n = 0; n < 4; n++) begin
      loadDigits(vec[n]);
      waitTick(found);
      captureFrame(4, ans, segs);
      total++;
      if (!found || ans !== ALL_AN || segs !== want[n]) begin
        bad++; $display("[TB] FAIL lzb_%h found=%0d an=%b seg=%b want %b %b",
                        vec[n], found, ans, segs, ALL_AN, want[n]);
      end
    end
    bus.lzb = 1'b0;
    waitTick(found);
    captureFrame(4, ans, segs);
    total++;
    if (segs !== {7'b1111111, 7'b0000001, 7'b1111111, 7'b0000001}) begin
      bad++; $display("[TB] FAIL lzb_off_F0F0 got %b want 1111111_0000001_1111111_0000001", segs);
    end
  endtask

  task automatic test_reset_mid();
    bit         found;
    logic [3:0] wantAn;
    int         c, i;
    waitTick(found);
    repeat (20) @(negedge clk);
    total++;
    if (!found || bus.anode !== 4'b1101) begin
      bad++; $display("[TB] FAIL mid_digit1 found=%0d an=%b want 1 1101", found, bus.anode);
    end
    loadDigits(16'h8888);
    total++;
    if (bus.pending !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_pending got %b want 1", bus.pending);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.anode, bus.segment, bus.pending, bus.frame_tick} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL async_reset got an=%b seg=%b pend=%b tick=%b want 1111 1111111 0 0",
                      bus.anode, bus.segment, bus.pending, bus.frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      c = (k - 1) % 8;
      i = 3 - ((k - 1) / 8) % 4;
      wantAn = (c < 2) ? 4'b1111 : ~(4'b0001 << i);
      total++;
      if ({bus.anode, bus.segment, bus.pending} !== {wantAn, 7'b1111111, 1'b0}) begin
        bad++; $display("[TB] FAIL restart k=%0d got an=%b seg=%b pend=%b want %b 1111111 0",
                        k, bus.anode, bus.segment, bus.pending, wantAn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_load_on_commit();
    test_lzb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
